// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter
//
// Shares one pipelined single-precision multiplier among NUM_REQ requesters.
// Requests are granted round-robin. The operands of the winner are registered
// onto the multiplier inputs one cycle after acceptance. The winner index is
// pushed into an in-order tag FIFO. The multiplier returns results in issue
// order, so each result pops the head tag. The result is then steered to that
// requester one cycle later.
//
// The FIFO depth bounds the number of multiplies in flight. A result that
// arrives while no tag is outstanding is dropped, and it sets a sticky error
// flag. Operand and product bits pass through untouched.

module fp_mult_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic [NUM_REQ-1:0]    reqValidIn,
    input  logic [32*NUM_REQ-1:0] reqDataAIn,
    input  logic [32*NUM_REQ-1:0] reqDataBIn,
    output logic [NUM_REQ-1:0]    reqReadyOut,
    output logic [31:0]           mulDataAOut,
    output logic [31:0]           mulDataBOut,
    output logic                  mulValidOut,
    input  logic [31:0]           mulDataIn,
    input  logic                  mulValidIn,
    output logic [NUM_REQ-1:0]    rspValidOut,
    output logic [31:0]           rspDataOut,
    output logic [31:0]           issueCountOut,
    output logic                  errorOut
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(TAG_DEPTH);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    // Arbitration state
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;

    // Tag FIFO state
    logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] head_tag;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic orphan;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign head_tag   = tag_mem[rd_ptr];

    // Round-robin search starting one past the last winner; blocked in reset or when the FIFO is full.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!rstIn && !fifo_full) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
                if (!grant_any && reqValidIn[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign reqReadyOut = grant_any ? (ONE_HOT0 << grant_idx) : '0;

    // The grant above already requires a valid request, so every grant is an acceptance.
    assign push   = grant_any;
    assign pop    = mulValidIn && !rstIn && !fifo_empty;
    assign orphan = mulValidIn && !rstIn && fifo_empty;

    // Issue stage: register the winner's operands, pulse the multiplier valid, and track fairness and the issue count.
    always_ff @(posedge clkIn) begin
        // NOTE: state registers use non-blocking assignments, so all flops update together from pre-edge values.
        if (rstIn) begin
            last_grant    <= IDX_W'(NUM_REQ - 1);
            mulValidOut   <= 1'b0;
            mulDataAOut   <= '0;
            mulDataBOut   <= '0;
            issueCountOut <= '0;
        end else begin
            mulValidOut <= push;
            if (push) begin
                last_grant    <= grant_idx;
                mulDataAOut   <= reqDataAIn[{grant_idx, 5'b0} +: 32];
                mulDataBOut   <= reqDataBIn[{grant_idx, 5'b0} +: 32];
                issueCountOut <= issueCountOut + 32'd1;
            end
        end
    end

    // Tag storage: write the winner index at the tail on every acceptance.
    always_ff @(posedge clkIn) begin
        // NOTE: the tag array has no reset; the pointers and count alone decide which entries are live.
        if (push) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    // FIFO bookkeeping: pointers wrap naturally, and the count holds when a push and a pop happen together.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Response stage: steer each popped result to its requester, and latch an orphan result as a sticky error.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            rspValidOut <= '0;
            rspDataOut  <= '0;
            errorOut    <= 1'b0;
        end else begin
            rspValidOut <= pop ? (ONE_HOT0 << head_tag) : '0;
            if (pop) begin
                rspDataOut <= mulDataIn;
            end
            if (orphan) begin
                errorOut <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter.
//
// A behavioural multiplier with a configurable latency sits behind the DUT and
// shares its reset. A monitor pushes the expected requester and product into a
// scoreboard on every accepted request. It pops and compares the scoreboard on
// every response strobe. Each scenario task adds its own timing and state
// checks.

module tb_fp_mult_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int TAG_DEPTH = 8;

    logic                  clkIn = 1'b0;
    logic                  rstIn = 1'b1;
    logic [NUM_REQ-1:0]    reqValidIn = '0;
    logic [32*NUM_REQ-1:0] reqDataAIn = '0;
    logic [32*NUM_REQ-1:0] reqDataBIn = '0;
    logic [NUM_REQ-1:0]    reqReadyOut;
    logic [31:0]           mulDataAOut;
    logic [31:0]           mulDataBOut;
    logic                  mulValidOut;
    logic [31:0]           mulDataIn = '0;
    logic                  mulValidIn = 1'b0;
    logic [NUM_REQ-1:0]    rspValidOut;
    logic [31:0]           rspDataOut;
    logic [31:0]           issueCountOut;
    logic                  errorOut;

    fp_mult_arbiter #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .reqValidIn   (reqValidIn),
        .reqDataAIn   (reqDataAIn),
        .reqDataBIn   (reqDataBIn),
        .reqReadyOut  (reqReadyOut),
        .mulDataAOut  (mulDataAOut),
        .mulDataBOut  (mulDataBOut),
        .mulValidOut  (mulValidOut),
        .mulDataIn    (mulDataIn),
        .mulValidIn   (mulValidIn),
        .rspValidOut  (rspValidOut),
        .rspDataOut   (rspDataOut),
        .issueCountOut(issueCountOut),
        .errorOut     (errorOut)
    );

    always #5 clkIn = ~clkIn;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cycle     = 0;
    int mul_lat   = 3;
    logic force_orphan = 1'b0;

    typedef struct { int due; logic [31:0] data; } pipe_t;
    typedef struct { int idx; logic [31:0] prod; } exp_t;
    pipe_t pipe_q[$];
    exp_t  sb_q[$];
    int    grant_log[$];

    // Truncating single-precision multiply for normal operands.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        logic [23:0] ma;
        logic [23:0] mb;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        ma = {1'b1, a[22:0]};
        mb = {1'b1, b[22:0]};
        p  = 48'(ma) * 48'(mb);
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_float();
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        s = 1'($urandom());
        e = 8'($urandom_range(110, 140));
        m = 23'($urandom());
        return {s, e, m};
    endfunction

    // Multiplier model: runs just after each rising edge and drives its output for the current cycle.
    always @(posedge clkIn) begin
        pipe_t p;
        #1;
        cycle++;
        if (rstIn) begin
            pipe_q.delete();
            mulValidIn = 1'b0;
            mulDataIn  = '0;
        end else begin
            mulValidIn = force_orphan;
            if (force_orphan) mulDataIn = 32'hDEAD_BEEF;
            if (pipe_q.size() > 0 && pipe_q[0].due == cycle) begin
                mulValidIn = 1'b1;
                mulDataIn  = pipe_q[0].data;
                void'(pipe_q.pop_front());
            end
            if (mulValidOut) begin
                p.due  = cycle + mul_lat;
                p.data = fp_mul(mulDataAOut, mulDataBOut);
                pipe_q.push_back(p);
            end
        end
    end

    // Scoreboard monitor: compare responses, then record acceptances, at the falling edge.
    always @(negedge clkIn) begin
        exp_t e;
        int gi;
        logic [NUM_REQ-1:0] acc;
        if (rspValidOut != '0) begin
            check_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got rspValidOut=%b data=%h, wanted no response", rspValidOut, rspDataOut);
            end else begin
                e = sb_q.pop_front();
                if (rspValidOut !== (NUM_REQ'(1) << e.idx) || rspDataOut !== e.prod)
                    $display("FAIL rsp_scoreboard: got %b/%h, wanted %b/%h", rspValidOut, rspDataOut, NUM_REQ'(1) << e.idx, e.prod);
                else
                    pass_cnt++;
            end
        end
        if (rstIn) begin
            sb_q.delete();
        end else begin
            if (reqReadyOut != '0) begin
                check_cnt++;
                if (!$onehot(reqReadyOut) || (reqReadyOut & ~reqValidIn) != '0)
                    $display("FAIL ready_onehot: got ready=%b valid=%b, wanted one granted valid bit", reqReadyOut, reqValidIn);
                else
                    pass_cnt++;
            end
            acc = reqValidIn & reqReadyOut;
            gi  = -1;
            for (int i = 0; i < NUM_REQ; i++) if (acc[i] && gi < 0) gi = i;
            if (gi >= 0) begin
                e.idx  = gi;
                e.prod = fp_mul(reqDataAIn[32*gi +: 32], reqDataBIn[32*gi +: 32]);
                sb_q.push_back(e);
                grant_log.push_back(gi);
            end
        end
    end

    task automatic step();
        @(posedge clkIn);
        #2;
    endtask

    task automatic do_reset();
        rstIn = 1'b1;
        step();
        rstIn = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || pipe_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        repeat (2) step();
        check_cnt++;
        if (sb_q.size() != 0) $display("FAIL drain: got %0d results pending, wanted 0", sb_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rstIn      = 1'b1;
        reqValidIn = '1;
        for (int i = 0; i < NUM_REQ; i++) reqDataAIn[32*i +: 32] = rand_float();
        step();
        step();
        @(negedge clkIn);
        check_cnt++;
        if (reqReadyOut !== '0) $display("FAIL reset_ready: got %b, wanted 0000", reqReadyOut);
        else pass_cnt++;
        check_cnt++;
        if ({mulValidOut, rspValidOut, errorOut} !== '0 || issueCountOut !== 32'd0)
            $display("FAIL reset_ctrl: got mv=%b rv=%b err=%b cnt=%0d, wanted all 0", mulValidOut, rspValidOut, errorOut, issueCountOut);
        else pass_cnt++;
        check_cnt++;
        if (mulDataAOut !== '0 || mulDataBOut !== '0 || rspDataOut !== '0)
            $display("FAIL reset_data: got %h %h %h, wanted 0", mulDataAOut, mulDataBOut, rspDataOut);
        else pass_cnt++;
        step();
        rstIn      = 1'b0;
        reqValidIn = '0;
        step();
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] exp_rv;
        mul_lat = 3;
        reqDataAIn[31:0] = 32'h4000_0000;
        reqDataBIn[31:0] = 32'h4040_0000;
        reqValidIn = 4'b0001;
        @(negedge clkIn);
        check_cnt++;
        if (reqReadyOut !== 4'b0001) $display("FAIL single_ready: got %b, wanted 0001", reqReadyOut);
        else pass_cnt++;
        step();
        reqValidIn = '0;
        @(negedge clkIn);
        check_cnt++;
        if (mulValidOut !== 1'b1 || mulDataAOut !== 32'h4000_0000 || mulDataBOut !== 32'h4040_0000)
            $display("FAIL single_issue: got v=%b A=%h B=%h, wanted 1 40000000 40400000", mulValidOut, mulDataAOut, mulDataBOut);
        else pass_cnt++;
        step();
        for (int k = 2; k <= 6; k++) begin
            @(negedge clkIn);
            exp_rv = (k == mul_lat + 2) ? 4'b0001 : 4'b0000;
            check_cnt++;
            if (rspValidOut !== exp_rv || (exp_rv != '0 && rspDataOut !== 32'h40C0_0000))
                $display("FAIL single_rsp_t%0d: got %b/%h, wanted %b/40c00000", k, rspValidOut, rspDataOut, exp_rv);
            else pass_cnt++;
            if (k == 2) begin
                check_cnt++;
                if (mulValidOut !== 1'b0 || mulDataAOut !== 32'h4000_0000)
                    $display("FAIL single_hold: got v=%b A=%h, wanted 0 40000000", mulValidOut, mulDataAOut);
                else pass_cnt++;
            end
            step();
        end
        drain();
    endtask

    task automatic test_fairness();
        do_reset();
        mul_lat = 3;
        grant_log.delete();
        reqValidIn = 4'hF;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                reqDataAIn[32*i +: 32] = rand_float();
                reqDataBIn[32*i +: 32] = rand_float();
            end
            @(negedge clkIn);
            check_cnt++;
            if (reqReadyOut !== (NUM_REQ'(1) << (c % NUM_REQ)))
                $display("FAIL fair_grant_%0d: got %b, wanted req %0d", c, reqReadyOut, c % NUM_REQ);
            else pass_cnt++;
            step();
        end
        reqValidIn = '0;
        @(negedge clkIn);
        check_cnt++;
        if (issueCountOut !== 32'd8) $display("FAIL fair_count: got %0d, wanted 8", issueCountOut);
        else pass_cnt++;
        check_cnt++;
        if (grant_log.size() != 8) $display("FAIL fair_log: got %0d grants, wanted 8", grant_log.size());
        else pass_cnt++;
        step();
        drain();
    endtask

    task automatic test_full_fifo();
        logic exp_rdy;
        do_reset();
        mul_lat = 20;
        reqValidIn = 4'b0001;
        for (int k = 0; k <= 30; k++) begin
            reqDataAIn[31:0] = rand_float();
            reqDataBIn[31:0] = rand_float();
            exp_rdy = (k < TAG_DEPTH) || (k >= 22 && k <= 29);
            @(negedge clkIn);
            check_cnt++;
            if (reqReadyOut[0] !== exp_rdy) $display("FAIL full_ready_k%0d: got %b, wanted %b", k, reqReadyOut[0], exp_rdy);
            else pass_cnt++;
            step();
        end
        reqValidIn = '0;
        @(negedge clkIn);
        check_cnt++;
        if (issueCountOut !== 32'd16) $display("FAIL full_count: got %0d, wanted 16", issueCountOut);
        else pass_cnt++;
        step();
        drain();
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] exp_rv;
        logic [31:0]        exp_d;
        mul_lat = 3;
        reqDataAIn[64 +: 32] = 32'h3FC0_0000;
        reqDataBIn[64 +: 32] = 32'h4080_0000;
        reqDataAIn[32 +: 32] = 32'hC000_0000;
        reqDataBIn[32 +: 32] = 32'h3F00_0000;
        reqValidIn = 4'b0100;
        @(negedge clkIn);
        check_cnt++;
        if (reqReadyOut !== 4'b0100) $display("FAIL route_ready2: got %b, wanted 0100", reqReadyOut);
        else pass_cnt++;
        step();
        reqValidIn = 4'b0010;
        @(negedge clkIn);
        check_cnt++;
        if (reqReadyOut !== 4'b0010) $display("FAIL route_ready1: got %b, wanted 0010", reqReadyOut);
        else pass_cnt++;
        step();
        reqValidIn = '0;
        for (int k = 2; k <= 7; k++) begin
            exp_rv = (k == mul_lat + 2) ? 4'b0100 : (k == mul_lat + 3) ? 4'b0010 : 4'b0000;
            exp_d  = (k == mul_lat + 2) ? 32'h40C0_0000 : 32'hBF80_0000;
            @(negedge clkIn);
            check_cnt++;
            if (rspValidOut !== exp_rv || (exp_rv != '0 && rspDataOut !== exp_d))
                $display("FAIL route_rsp_t%0d: got %b/%h, wanted %b/%h", k, rspValidOut, rspDataOut, exp_rv, exp_d);
            else pass_cnt++;
            step();
        end
        drain();
    endtask

    task automatic test_orphan();
        @(negedge clkIn);
        check_cnt++;
        if (errorOut !== 1'b0) $display("FAIL orphan_pre: got %b, wanted 0", errorOut);
        else pass_cnt++;
        step();
        force_orphan = 1'b1;
        step();
        force_orphan = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            @(negedge clkIn);
            check_cnt++;
            if (errorOut !== 1'b1 || rspValidOut !== '0)
                $display("FAIL orphan_k%0d: got err=%b rv=%b, wanted 1 0000", k, errorOut, rspValidOut);
            else pass_cnt++;
        end
        step();
        reqDataAIn[32 +: 32] = rand_float();
        reqDataBIn[32 +: 32] = rand_float();
        reqValidIn = 4'b0010;
        step();
        reqValidIn = '0;
        drain();
    endtask

    task automatic test_reset_midstream();
        mul_lat = 10;
        reqValidIn = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            reqDataAIn[31:0] = rand_float();
            step();
        end
        rstIn      = 1'b1;
        reqValidIn = 4'b1001;
        @(negedge clkIn);
        check_cnt++;
        if (reqReadyOut !== '0 || mulValidOut !== 1'b1)
            $display("FAIL midrst_during: got ready=%b mv=%b, wanted 0000 1", reqReadyOut, mulValidOut);
        else pass_cnt++;
        step();
        rstIn      = 1'b0;
        reqValidIn = '0;
        @(negedge clkIn);
        check_cnt++;
        if ({reqReadyOut, mulValidOut, rspValidOut, errorOut} !== '0 || issueCountOut !== 32'd0 ||
            mulDataAOut !== '0 || mulDataBOut !== '0 || rspDataOut !== '0)
            $display("FAIL midrst_after: got rdy=%b mv=%b rv=%b err=%b cnt=%0d A=%h B=%h R=%h, wanted all 0",
                     reqReadyOut, mulValidOut, rspValidOut, errorOut, issueCountOut, mulDataAOut, mulDataBOut, rspDataOut);
        else pass_cnt++;
        step();
        reqDataAIn[96 +: 32] = rand_float();
        reqDataBIn[96 +: 32] = rand_float();
        reqValidIn = 4'b1001;
        @(negedge clkIn);
        check_cnt++;
        if (reqReadyOut !== 4'b0001) $display("FAIL midrst_prio: got %b, wanted 0001", reqReadyOut);
        else pass_cnt++;
        step();
        reqValidIn = 4'b1000;
        @(negedge clkIn);
        check_cnt++;
        if (reqReadyOut !== 4'b1000) $display("FAIL midrst_req3: got %b, wanted 1000", reqReadyOut);
        else pass_cnt++;
        step();
        reqValidIn = '0;
        drain();
        check_cnt++;
        if (issueCountOut !== 32'd2) $display("FAIL midrst_count: got %0d, wanted 2", issueCountOut);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full_fifo();
        test_back_to_back();
        test_orphan();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/fp_mult_arbiter.md
FP_MULT_ARBITER -- requirements
Module: fp_mult_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one floating_point_multiply instance.
REQ-002 SHALL have parameter TAG_DEPTH, default 8: maximum multiplies in flight; power of two, at least 2.
REQ-003 SHALL have port clkIn, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstIn, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port reqValidIn, input, NUM_REQ bits: per-requester operand valid.
REQ-006 SHALL have port reqDataAIn, input, 32*NUM_REQ bits: IEEE-754 single-precision operand A; requester i occupies bits [32i+31:32i].
REQ-007 SHALL have port reqDataBIn, input, 32*NUM_REQ bits: operand B, packed the same way as reqDataAIn.
REQ-008 SHALL have port reqReadyOut, output, NUM_REQ bits: one-hot grant; a transfer occurs when reqValidIn[i] and reqReadyOut[i] are both high.
REQ-009 SHALL have port mulDataAOut, output, 32 bits: operand A to the multiplier's dataAIn.
REQ-010 SHALL have port mulDataBOut, output, 32 bits: operand B to the multiplier's dataBIn.
REQ-011 SHALL have port mulValidOut, output, 1 bit: drives the multiplier's validIn.
REQ-012 SHALL have port mulDataIn, input, 32 bits: from the multiplier's dataOut.
REQ-013 SHALL have port mulValidIn, input, 1 bit: from the multiplier's validOut.
REQ-014 SHALL have port rspValidOut, output, NUM_REQ bits: one-hot result strobe; there is no backpressure.
REQ-015 SHALL have port rspDataOut, output, 32 bits: product, meaningful only while a bit of rspValidOut is high.
REQ-016 SHALL have port issueCountOut, output, 32 bits: total accepted requests, wrapping modulo 2^32.
REQ-017 SHALL have port errorOut, output, 1 bit: sticky flag for a result with no matching outstanding tag.

Function
REQ-018 SHALL assert reqReadyOut combinationally, at most one bit per cycle, only when the tag FIFO count < TAG_DEPTH and rstIn is low.
REQ-019 SHALL grant round-robin: search starts at (lastGrant+1) mod NUM_REQ; the first requester with valid high wins.
REQ-020 SHALL update lastGrant only in a cycle where a grant occurs.
REQ-021 SHALL, on acceptance in cycle t, register the winner's operands onto mulDataAOut/mulDataBOut and assert mulValidOut in cycle t+1 for exactly one cycle per acceptance.
REQ-022 SHALL hold mulValidOut low when there is no acceptance; mulDataA/BOut then hold their last values.
REQ-023 SHALL, in cycle t, push the winner index into an in-order tag FIFO of depth TAG_DEPTH; the multiplier returns results in issue order.
REQ-024 SHALL, when mulValidIn is high in cycle u with the FIFO non-empty, pop the head tag h.
REQ-025 SHALL, on that pop, drive rspValidOut = one-hot(h) and rspDataOut = mulDataIn in cycle u+1, with rspValidOut zero in other cycles.
REQ-026 SHALL, on a simultaneous push and pop, leave the count unchanged and keep FIFO order correct, including at pointer wrap-around.
REQ-027 SHALL not issue when the count equals TAG_DEPTH, even if a pop occurs in the same cycle; issue resumes the following cycle.
REQ-028 SHALL, when mulValidIn is high with the FIFO empty, set errorOut, drop the result, pulse no rspValidOut, and keep the count at 0.
REQ-029 SHALL increment issueCountOut by 1 per acceptance, wrapping 0xFFFFFFFF to 0.
REQ-030 SHALL not modify or inspect operand/product values (no NaN or exception handling).

Reset
REQ-031 SHALL, with rstIn high at a clock edge, clear reqReadyOut, mulValidOut, rspValidOut, errorOut, issueCountOut, mulDataA/BOut, rspDataOut, FIFO pointers and count to 0.
REQ-032 SHALL, on reset, set lastGrant to NUM_REQ-1 so requester 0 has first priority.
REQ-033 SHALL, on reset mid-operation, discard all in-flight tags; the multiplier shares rstIn, so no stale results return.
REQ-034 SHALL ignore mulValidIn while rstIn is high.

Verification
REQ-035 SHALL cover single request: req0 A=0x40000000 (2.0), B=0x40400000 (3.0), multiplier latency L -> mulValidOut at t+1, rspValidOut=0001 and rspDataOut=0x40C00000 at t+1+L+1.
REQ-036 SHALL cover fairness: all four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3 and issueCountOut=8.
REQ-037 SHALL cover full FIFO: multiplier latency > TAG_DEPTH with constant requests -> exactly 8 issues, then reqReadyOut=0 until the first result pops, then one issue on the next cycle.
REQ-038 SHALL cover routing: req2 then req1 issued back-to-back -> rspValidOut=0100 then 0010 on consecutive cycles with the matching products.
REQ-039 SHALL cover orphan result: mulValidIn forced high with the FIFO empty -> errorOut=1 (sticky), rspValidOut stays 0.
REQ-040 SHALL cover reset mid-stream: rstIn high for one cycle with 3 tags outstanding -> all outputs 0 next cycle, then a req3 request is granted before req0 only if req0 is idle.
